router_wrr_arbiter: RTL and testbench
=====================================

Name: router_wrr_arbiter

Overview:
N-input to 1-output wormhole arbiter for router output ports, generalising the fixed 4- and 5-input arbiters to any input count. It adds per-input weighted round-robin, which lets one input win up to weight[i] consecutive packets before priority rotates. The grant stays held across the locked packet, and protocol violations raise a sticky error flag. One instance sits per router output port; the fork/multicast and plain variants both map onto it.

Parameters:
NUM_IN, 5, number of input ports (2..8)
WEIGHT_W, 3, width of each per-input weight and of the burst counter

Ports:
clk  in  1  clock
rst  in  1  reset; one clock domain; reset is asynchronous, active-high
request  in  NUM_IN  bit i set: input i has a valid flit for this output
weight  in  NUM_IN*WEIGHT_W  packets per turn for each input; quasi-static; 0 is treated as 1
forwarding_head  in  1  head flit of the granted packet is transferred this cycle
forwarding_tail  in  1  tail flit is transferred this cycle (may coincide with head: single-flit packet)
grant  out  NUM_IN  one-hot or zero
grant_valid  out  1  grant is usable this cycle
locked  out  1  a packet is in flight; grant frozen
burst_cnt  out  WEIGHT_W  packets already granted to the current priority holder (debug/verification)
protocol_err  out  1  sticky violation flag

Behaviour:
- Reset (async assert, sync deassert internally handled by the rst tree):
  - locked=0, saved_grant=0, ptr=0, burst_cnt=0, protocol_err=0.
  - grant and grant_valid are then purely combinational from request; both are 0 when request=0.
- Unlocked grant path:
  - grant = first set bit of request, searching circularly from ptr upward (ptr, ptr+1 ... wrap to 0). Zero delay.
  - grant_valid = |request.
- Locked grant path:
  - grant = saved_grant, independent of request.
  - grant_valid = |(request & saved_grant).
- Head accepted: forwarding_head=1, locked=0, grant!=0.
  - saved_grant<=grant.
  - locked<=~forwarding_tail, so a single-flit packet never locks.
  - Weight update: let g = granted index and W = max(weight[g],1).
  - If g==ptr: if burst_cnt+1>=W, then ptr<=(g+1) mod NUM_IN and burst_cnt<=0; otherwise burst_cnt<=burst_cnt+1.
  - If g!=ptr (holder was idle and skipped): if W==1, then ptr<=(g+1) mod NUM_IN and burst_cnt<=0; otherwise ptr<=g and burst_cnt<=1.
- Tail while locked:
  - locked<=0 and saved_grant<=0. ptr and burst_cnt are unchanged.
- Errors (each sets protocol_err, which stays 1 until rst):
  - forwarding_head while locked (the head is ignored).
  - forwarding_tail while unlocked without a simultaneous head.
  - forwarding_head with grant==0.
  - While locked, the granted request bit dropping before the tail.
  - State is unchanged on every error except the flag.
- Simultaneous head+tail while locked: the head is an error; the tail still unlocks.
- Wrap-around: ptr from NUM_IN-1 goes to 0. burst_cnt saturates at 2^WEIGHT_W-1; with the weight rules it cannot exceed W-1.
- Reset mid-packet: state clears immediately. Upstream is responsible for discarding the partial packet.
- Assertions (non-synthesis): grant is onehot0; grant is a subset of request whenever grant_valid=1.

Decomposition:
- Package router_arb_pkg:
  - function clog2-based index width
  - weight typedef logic [WEIGHT_W-1:0]
  - ERR codes for an optional future error-cause register
- Sub-module rr_priority_picker (parametrised NUM_IN):
  - combinational rotate-by-ptr, find-first, rotate-back
  - outputs one-hot grant and binary index
  - reused by future VC allocators

Test Plan:
- NUM_IN=5, all weights 1, request=5'b11111, one single-flit packet per cycle → grants 0,1,2,3,4,0 in order; locked stays 0.
- weight[1]=3, others 1, request=5'b00010 then 5'b00011 after 3 packets → three grants to input 1, then input 0 wins after the wrap; burst_cnt goes 1,2,0.
- 4-flit packet from input 2 (head, 2 bodies, tail) while request[3] rises mid-packet → grant stays 5'b00100 through the tail; grant=5'b01000 in the cycle after the tail.
- rst asserted asynchronously mid-packet (locked=1, ptr=3) → locked, ptr, burst_cnt and protocol_err read 0 before the next clk edge; a subsequent request=5'b10001 grants input 0.
- Second forwarding_head while locked → protocol_err=1 from the next cycle; saved_grant and ptr unchanged; the following tail unlocks normally.
- ptr=2 with input 2 idle, request=5'b10001, weight[4]=2 → grant 5'b10000; afterwards ptr=4 and burst_cnt=1.

Source files
------------

// File: rtl/router_arb_pkg.sv
// Shared definitions for the router output-port arbiter family.
//   idx_w()     : width of a binary port index for n inputs (minimum 1)
//   weight_t    : per-input weight at the default weight width
//   err_code_t  : cause codes reserved for a future error-cause register
package router_arb_pkg;

  localparam int DEF_WEIGHT_W = 3;

  typedef logic [DEF_WEIGHT_W-1:0] weight_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_HEAD_LOCKED,
    ERR_TAIL_UNLOCKED,
    ERR_HEAD_NO_GRANT,
    ERR_REQ_DROP
  } err_code_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Circular find-first picker: rotate the request vector down by ptr,
// find the lowest set bit, then rotate the result back.
//   req : request vector
//   ptr : highest-priority position
//   gnt : one-hot grant (zero when req is zero)
//   idx : binary index of the granted input
//   any : at least one request present
module rr_priority_picker
  import router_arb_pkg::*;
#(
  parameter int NUM_IN = 5,
  parameter int IW     = idx_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [IW-1:0]     idx,
  output logic              any
);

  logic [NUM_IN-1:0] rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;
  logic              found;

  always_comb begin
    // Doubling the vector makes the right shift a rotation.
    rot   = NUM_IN'({req, req} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = IW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(NUM_IN)) sum = sum - (IW+1)'(NUM_IN);
    idx = sum[IW-1:0];
    gnt = found ? (NUM_IN'(1) << idx) : '0;
    any = found;
  end

endmodule

// File: rtl/router_wrr_arbiter.sv
// N-input wormhole arbiter for one router output port with weighted
// round-robin: the priority holder may win up to weight[i] consecutive
// packets before priority rotates. The grant is frozen while a packet
// is in flight; protocol violations raise a sticky error flag.
//   clk, rst        : clock, asynchronous active-high reset
//   request         : per-input flit-valid
//   weight          : packed per-input weights (0 behaves as 1)
//   forwarding_head : head flit of the granted packet moves this cycle
//   forwarding_tail : tail flit moves this cycle
//   grant           : one-hot or zero
//   grant_valid     : grant usable this cycle
//   locked          : packet in flight
//   burst_cnt       : packets already granted to the current holder
//   protocol_err    : sticky violation flag
module router_wrr_arbiter
  import router_arb_pkg::*;
#(
  parameter int NUM_IN   = 5,
  parameter int WEIGHT_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IN-1:0]          request,
  input  logic [NUM_IN*WEIGHT_W-1:0] weight,
  input  logic                       forwarding_head,
  input  logic                       forwarding_tail,
  output logic [NUM_IN-1:0]          grant,
  output logic                       grant_valid,
  output logic                       locked,
  output logic [WEIGHT_W-1:0]        burst_cnt,
  output logic                       protocol_err
);

  localparam int IW = idx_w(NUM_IN);

  logic [NUM_IN-1:0]   saved_grant;
  logic [IW-1:0]       ptr;

  logic [NUM_IN-1:0]   pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  rr_priority_picker #(.NUM_IN(NUM_IN), .IW(IW)) u_pick (
    .req (request),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign grant       = locked ? saved_grant : pick_gnt;
  assign grant_valid = locked ? |(request & saved_grant) : |request;

  // Event classification
  logic head_ok, tail_ok, err_now;
  assign head_ok = forwarding_head && !locked && pick_any;
  assign tail_ok = forwarding_tail && locked;
  assign err_now = (forwarding_head && locked)
                 || (forwarding_tail && !locked && !forwarding_head)
                 || (forwarding_head && !locked && !pick_any)
                 || (locked && !(|(request & saved_grant)));

  // Weighted round-robin bookkeeping for an accepted head
  logic [WEIGHT_W-1:0] w_raw;
  logic [WEIGHT_W:0]   w_eff, cnt_inc;
  logic [IW:0]         idx_inc;
  logic [IW-1:0]       next_after_g;
  logic [IW-1:0]       ptr_nxt;
  logic [WEIGHT_W-1:0] burst_nxt;

  always_comb begin
    w_raw = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (pick_idx == IW'(i)) w_raw = weight[i*WEIGHT_W +: WEIGHT_W];
    w_eff   = (w_raw == '0) ? (WEIGHT_W+1)'(1) : {1'b0, w_raw};
    cnt_inc = {1'b0, burst_cnt} + (WEIGHT_W+1)'(1);

    idx_inc      = {1'b0, pick_idx} + (IW+1)'(1);
    next_after_g = (idx_inc == (IW+1)'(NUM_IN)) ? '0 : idx_inc[IW-1:0];

    ptr_nxt   = ptr;
    burst_nxt = burst_cnt;
    if (pick_idx == ptr) begin
      if (cnt_inc >= w_eff) begin
        ptr_nxt   = next_after_g;
        burst_nxt = '0;
      end else begin
        burst_nxt = cnt_inc[WEIGHT_W-1:0];
      end
    end else begin
      // Holder was idle and got skipped: the winner starts its own turn.
      if (w_eff == (WEIGHT_W+1)'(1)) begin
        ptr_nxt   = next_after_g;
        burst_nxt = '0;
      end else begin
        ptr_nxt   = pick_idx;
        burst_nxt = WEIGHT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked       <= 1'b0;
      saved_grant  <= '0;
      ptr          <= '0;
      burst_cnt    <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (err_now) protocol_err <= 1'b1;
      if (head_ok) begin
        saved_grant <= pick_gnt;
        locked      <= ~forwarding_tail;
        ptr         <= ptr_nxt;
        burst_cnt   <= burst_nxt;
      end else if (tail_ok) begin
        locked      <= 1'b0;
        saved_grant <= '0;
      end
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_subset: assert property (@(posedge clk) disable iff (rst)
                             grant_valid |-> ((grant & ~request) == '0));

endmodule

// File: tb/tb_router_wrr_arbiter.sv
module tb_router_wrr_arbiter;

  localparam int N  = 5;
  localparam int WW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  request = '0;
  logic [N*WW-1:0] weight = '0;
  logic          fh = 1'b0, ft = 1'b0;
  logic [N-1:0]  grant;
  logic          grant_valid, locked, protocol_err;
  logic [WW-1:0] burst_cnt;

  router_wrr_arbiter #(.NUM_IN(N), .WEIGHT_W(WW)) dut (
    .clk             (clk),
    .rst             (rst),
    .request         (request),
    .weight          (weight),
    .forwarding_head (fh),
    .forwarding_tail (ft),
    .grant           (grant),
    .grant_valid     (grant_valid),
    .locked          (locked),
    .burst_cnt       (burst_cnt),
    .protocol_err    (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*WW-1:0] w;
    logic [N-1:0]    req;
    logic            fh, ft;
    logic [N-1:0]    g;
    logic            gv, lk;
    logic [WW-1:0]   bc;
    logic            err;
  } vec_t;

  typedef struct packed {
    logic [N-1:0]  g;
    logic          gv, lk;
    logic [WW-1:0] bc;
    logic          err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   sb_id[$];
  int   tests = 0, fails = 0;

  localparam logic [N*WW-1:0] W1  = {3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
  localparam logic [N*WW-1:0] W_B = {3'd1, 3'd1, 3'd1, 3'd3, 3'd1};
  localparam logic [N*WW-1:0] W_C = {3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
  localparam logic [N*WW-1:0] W_D = {3'd1, 3'd2, 3'd1, 3'd1, 3'd1};

  function automatic void add(logic [N*WW-1:0] w, logic [N-1:0] rq, logic h, logic t,
                              logic [N-1:0] g, logic gv, logic lk, logic [WW-1:0] bc,
                              logic err);
    vec_t v;
    v.w = w; v.req = rq; v.fh = h; v.ft = t;
    v.g = g; v.gv = gv; v.lk = lk; v.bc = bc; v.err = err;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: outputs are combinational on the current state,
  // so each pushed expectation is checked at the following falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      int   id;
      e  = sb.pop_front();
      id = sb_id.pop_front();
      check($sformatf("vec%0d", id),
            32'({grant, grant_valid, locked, burst_cnt, protocol_err}), 32'(e));
    end
  end

  initial begin
    // Fields: weights, request, head, tail | grant, gv, locked, burst, err
    // Round robin, all weights 1, single-flit packets every cycle
    add(W1, 5'b11111, 1, 1, 5'b00001, 1, 0, 0, 0);
    add(W1, 5'b11111, 1, 1, 5'b00010, 1, 0, 0, 0);
    add(W1, 5'b11111, 1, 1, 5'b00100, 1, 0, 0, 0);
    add(W1, 5'b11111, 1, 1, 5'b01000, 1, 0, 0, 0);
    add(W1, 5'b11111, 1, 1, 5'b10000, 1, 0, 0, 0);
    add(W1, 5'b11111, 1, 1, 5'b00001, 1, 0, 0, 0);
    // weight[1]=3: three packets for input 1, then input 0 after wrap
    add(W_B, 5'b00010, 1, 1, 5'b00010, 1, 0, 0, 0);
    add(W_B, 5'b00010, 1, 1, 5'b00010, 1, 0, 1, 0);
    add(W_B, 5'b00010, 1, 1, 5'b00010, 1, 0, 2, 0);
    add(W_B, 5'b00011, 1, 1, 5'b00001, 1, 0, 0, 0);
    // 4-flit packet from input 2, request[3] rises mid-packet
    add(W1, 5'b00100, 1, 0, 5'b00100, 1, 0, 0, 0);
    add(W1, 5'b01100, 0, 0, 5'b00100, 1, 1, 0, 0);
    add(W1, 5'b01100, 0, 0, 5'b00100, 1, 1, 0, 0);
    add(W1, 5'b01100, 0, 1, 5'b00100, 1, 1, 0, 0);
    add(W1, 5'b01000, 0, 0, 5'b01000, 1, 0, 0, 0);
    // Second head while locked
    add(W1, 5'b01000, 1, 0, 5'b01000, 1, 0, 0, 0);
    add(W1, 5'b01000, 1, 0, 5'b01000, 1, 1, 0, 0);
    add(W1, 5'b01000, 0, 0, 5'b01000, 1, 1, 0, 1);
    add(W1, 5'b01000, 0, 1, 5'b01000, 1, 1, 0, 1);
    add(W1, 5'b11111, 0, 0, 5'b10000, 1, 0, 0, 1);
    // Idle holder skipped: ptr=2, input 4 weight 2 -> ptr=4, burst=1
    add(W1,  5'b00010, 1, 1, 5'b00010, 1, 0, 0, 1);
    add(W_C, 5'b10001, 1, 1, 5'b10000, 1, 0, 0, 1);
    add(W_C, 5'b10001, 0, 0, 5'b10000, 1, 0, 1, 1);
    add(W_C, 5'b10000, 1, 1, 5'b10000, 1, 0, 1, 1);
    // Set up locked with ptr=3 for the reset case
    add(W_D, 5'b00100, 1, 1, 5'b00100, 1, 0, 0, 1);
    add(W_D, 5'b01000, 1, 0, 5'b01000, 1, 0, 0, 1);
    add(W_D, 5'b01000, 0, 0, 5'b01000, 1, 1, 1, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'({grant, grant_valid, locked, burst_cnt, protocol_err}), 32'(0));
    rst = 1'b0;

    foreach (vecs[k]) begin
      exp_t e;
      @(posedge clk);
      #1;
      weight = vecs[k].w; request = vecs[k].req; fh = vecs[k].fh; ft = vecs[k].ft;
      e.g = vecs[k].g; e.gv = vecs[k].gv; e.lk = vecs[k].lk; e.bc = vecs[k].bc; e.err = vecs[k].err;
      sb.push_back(e);
      sb_id.push_back(k);
    end
    @(negedge clk);
    #2;

    // Async reset mid-packet: state clears before the next edge
    rst = 1'b1;
    #1;
    check("rst_async", 32'({locked, burst_cnt, protocol_err, grant}), 32'({1'b0, 3'd0, 1'b0, 5'b01000}));
    @(posedge clk);
    #1;
    rst = 1'b0; request = 5'b10001; weight = W1;
    #1;
    check("post_rst_grant", 32'({grant, grant_valid}), 32'({5'b00001, 1'b1}));

    // Head with nothing to grant
    request = '0; fh = 1'b1;
    #1;
    check("idle_grant", 32'({grant, grant_valid}), 32'(0));
    @(posedge clk);
    #1;
    fh = 1'b0;
    check("head_nogrant_err", 32'({protocol_err, locked}), 32'(2'b10));

    // Tail without head while unlocked
    rst = 1'b1; #1; rst = 1'b0;
    ft = 1'b1;
    @(posedge clk);
    #1;
    ft = 1'b0;
    check("tail_unlocked_err", 32'({protocol_err, locked}), 32'(2'b10));

    // Weight 0 behaves as 1 for a skipped holder
    rst = 1'b1; #1; rst = 1'b0;
    weight = '0; request = 5'b00010; fh = 1'b1; ft = 1'b1;
    @(posedge clk);
    #1;
    fh = 1'b0; ft = 1'b0; request = 5'b00110;
    #1;
    check("w0_as_1", 32'({grant, burst_cnt, protocol_err}), 32'({5'b00100, 3'd0, 1'b0}));

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
